// File: rtl/sri_master_tx.sv
// sri_master_tx: serial word transmitter (sclk/MOSI/load), MSB first.
// sclk idles low, the receiver samples MOSI on sclk rising edges, and a load
// strobe follows the last bit so the receiver can latch its shift register.
// Optional feature macro: SRI_TX_DBUF_EN adds a one-word hold buffer so the
// next word can be queued while a transfer is in progress.
module sri_master_tx #(
  parameter int unsigned N   = 64,
  parameter int unsigned DIV = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st,
  input  logic [N-1:0] DI,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic         sclk,
  output logic         MOSI,
  output logic         load
);

  localparam int unsigned HW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_shift;
  logic [HW-1:0]   r_hcnt;
  logic [BW-1:0]   r_bcnt;
  logic            r_sclk;
  logic            r_mosi;
  logic            r_load;
  logic            r_busy;
  logic            r_done;
  logic            r_ready;
`ifdef SRI_TX_DBUF_EN
  logic [N-1:0]    r_hold;
  logic            r_full;
`endif

  logic            w_half_end;
  logic            w_bit_last;
  logic [N-1:0]    w_shift_nxt;
  logic            w_load_end;

  // Terminal counts and the next shift-register value
  assign w_half_end  = (r_hcnt == HW'(DIV - 1));
  assign w_bit_last  = (r_bcnt == BW'(N - 1));
  assign w_shift_nxt = r_shift << 1;
  assign w_load_end  = (r_state == LOAD) && w_half_end;

  // Transfer state machine; all outputs come straight from registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_hcnt  <= '0;
      r_bcnt  <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_load  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
`ifdef SRI_TX_DBUF_EN
      r_hold  <= '0;
      r_full  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (st) begin
            r_shift <= DI;
            r_mosi  <= DI[N-1];
            r_sclk  <= 1'b0;
            r_hcnt  <= '0;
            r_bcnt  <= '0;
            r_busy  <= 1'b1;
`ifdef SRI_TX_DBUF_EN
            r_ready <= 1'b1;
`else
            r_ready <= 1'b0;
`endif
            r_state <= SHIFT;
          end
        end

        SHIFT: begin
          if (w_half_end) begin
            r_hcnt <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else if (w_bit_last) begin
              // last falling toggle: park sclk low and raise load
              r_sclk  <= 1'b0;
              r_mosi  <= 1'b0;
              r_load  <= 1'b1;
              r_state <= LOAD;
            end else begin
              // falling toggle: present the next bit
              r_sclk  <= 1'b0;
              r_shift <= w_shift_nxt;
              r_mosi  <= w_shift_nxt[N-1];
              r_bcnt  <= r_bcnt + BW'(1);
            end
          end else begin
            r_hcnt <= r_hcnt + HW'(1);
          end
        end

        LOAD: begin
          if (w_half_end) begin
            r_hcnt <= '0;
            r_load <= 1'b0;
            r_done <= 1'b1;
            r_bcnt <= '0;
`ifdef SRI_TX_DBUF_EN
            if (r_full) begin
              // chain the held word from this edge
              r_shift <= r_hold;
              r_mosi  <= r_hold[N-1];
              r_full  <= 1'b0;
              r_ready <= 1'b1;
              r_state <= SHIFT;
            end else if (st) begin
              // new word offered in the done cycle starts directly
              r_shift <= DI;
              r_mosi  <= DI[N-1];
              r_state <= SHIFT;
            end else begin
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
              r_state <= IDLE;
            end
`else
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
`endif
          end else begin
            r_hcnt <= r_hcnt + HW'(1);
          end
        end

        default: r_state <= IDLE;
      endcase

`ifdef SRI_TX_DBUF_EN
      // queue a word offered mid-transfer when the hold slot is free
      if (st && r_busy && !r_full && !w_load_end) begin
        r_hold  <= DI;
        r_full  <= 1'b1;
        r_ready <= 1'b0;
      end
`endif
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign sclk  = r_sclk;
  assign MOSI  = r_mosi;
  assign load  = r_load;

endmodule

// File: tb/tb_sri_master_tx.sv
// Bench for sri_master_tx: N=8 with DIV=2 and DIV=1 instances, a receiver
// model feeding a word scoreboard, and a cycle-exact timing model.
module tb_sri_master_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       st0 = 1'b0, st1 = 1'b0;
  logic [7:0] di0 = 8'h00, di1 = 8'h00;
  logic       ready0, busy0, done0, sclk0, mosi0, load0;
  logic       ready1, busy1, done1, sclk1, mosi1, load1;

  sri_master_tx #(.N(8), .DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .st(st0), .DI(di0),
    .ready(ready0), .busy(busy0), .done(done0),
    .sclk(sclk0), .MOSI(mosi0), .load(load0)
  );

  sri_master_tx #(.N(8), .DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .st(st1), .DI(di1),
    .ready(ready1), .busy(busy1), .done(done1),
    .sclk(sclk1), .MOSI(mosi1), .load(load1)
  );

  always #5 clk = ~clk;

  int         n_err = 0;
  int         n_chk = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] rx     [2];
  int         rises  [2];
  int         loads  [2];
  logic       p_sclk [2];
  logic       p_load [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Receiver model: shift on sclk rise, compare latched word on load rise
  task automatic mon(input int s, input logic sc, input logic mo, input logic ld);
    logic [7:0] e;
    logic       empty;
    if (sc && !p_sclk[s]) begin
      rx[s] = {rx[s][6:0], mo};
      rises[s]++;
    end
    if (ld && !p_load[s]) begin
      loads[s]++;
      chk($sformatf("dut%0d sclk rises per word", s), 32'(rises[s]), 32'd8);
      rises[s] = 0;
      empty = (s == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        n_chk++;
        n_err++;
        $display("FAIL dut%0d unexpected load: DO=%02h with no word expected", s, rx[s]);
      end else begin
        e = (s == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("dut%0d DO", s), 32'(rx[s]), 32'(e));
      end
    end
    p_sclk[s] = sc;
    p_load[s] = ld;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        rx[s] = 8'h00; rises[s] = 0; p_sclk[s] = 1'b0; p_load[s] = 1'b0;
      end
    end else begin
      mon(0, sclk0, mosi0, load0);
      mon(1, sclk1, mosi1, load1);
    end
  end

  function automatic logic [4:0] rd(input int sel);
    return (sel == 0) ? {ready0, busy0, done0, sclk0, load0}
                      : {ready1, busy1, done1, sclk1, load1};
  endfunction

  function automatic logic rdm(input int sel);
    return (sel == 0) ? mosi0 : mosi1;
  endfunction

  task automatic drv(input int sel, input logic s, input logic [7:0] d);
    if (sel == 0) begin st0 = s; di0 = d; end
    else begin st1 = s; di1 = d; end
  endtask

  // Start word w, then check every cycle against the timing model.
  // nw chained words; ik/ik2 are edges (rel. E0) where extra st pulses land;
  // ready is expected low for k in [ra, rb].
  task automatic xfer(input int sel, input int d, input logic [7:0] w, input int nw,
                      input int ik, input logic [7:0] id, input int ik2, input logic [7:0] id2,
                      input int ra, input int rb);
    int T, P, kk;
    logic [4:0] e;
    T = 16 * d;
    P = T + d;
    @(negedge clk); drv(sel, 1'b1, w);
    @(posedge clk); #1;
    chk($sformatf("sel%0d w%02h MOSI at E0", sel, w), 32'(rdm(sel)), 32'(w[7]));
    for (int k = 0; k <= nw * P + 2; k++) begin
      kk = k % P;
      e[4] = !(k >= ra && k <= rb);
      e[3] = (k < nw * P);
      e[2] = (k > 0) && (k % P == 0) && (k <= nw * P);
      e[1] = (k < nw * P) && (kk < T) && (((kk / d) % 2) == 1);
      e[0] = (k < nw * P) && (kk >= T);
      chk($sformatf("sel%0d w%02h k=%0d ready,busy,done,sclk,load", sel, w, k),
          32'(rd(sel)), 32'(e));
      if (k + 1 == ik)       drv(sel, 1'b1, id);
      else if (k + 1 == ik2) drv(sel, 1'b1, id2);
      else                   drv(sel, 1'b0, 8'h00);
      @(posedge clk); #1;
    end
    drv(sel, 1'b0, 8'h00);
  endtask

  initial begin
    int ld_before;
    int exp_loads0;

    // reset state
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset dut0 ready,busy,done,sclk,load", 32'(rd(0)), 32'b10000);
    chk("reset dut1 ready,busy,done,sclk,load", 32'(rd(1)), 32'b10000);
    chk("reset dut0 MOSI", 32'(mosi0), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // single word, plus a start that must not disturb it
    q0.push_back(8'hA5);
`ifdef SRI_TX_DBUF_EN
    xfer(0, 2, 8'hA5, 1, 0, 8'h00, 0, 8'h00, 1, 0);
`else
    xfer(0, 2, 8'hA5, 1, 5, 8'h3C, 0, 8'h00, 0, 33);
`endif

    // reset in the middle of a transfer
    @(negedge clk); st0 = 1'b1; di0 = 8'hE7;
    @(posedge clk); #1 st0 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre-reset sclk", 32'(sclk0), 32'd1);
    chk("pre-reset MOSI", 32'(mosi0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-reset ready,busy,done,sclk,load", 32'(rd(0)), 32'b10000);
    chk("mid-reset MOSI", 32'(mosi0), 32'd0);
    ld_before = loads[0];
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("no load after abort", 32'(loads[0]), 32'(ld_before));
    chk("idle after abort", 32'(rd(0)), 32'b10000);

    q0.push_back(8'hFF);
`ifdef SRI_TX_DBUF_EN
    xfer(0, 2, 8'hFF, 1, 0, 8'h00, 0, 8'h00, 1, 0);
    // back-to-back through the hold buffer, third start ignored while full
    q0.push_back(8'h81);
    q0.push_back(8'h7E);
    xfer(0, 2, 8'h81, 2, 4, 8'h7E, 10, 8'h55, 4, 33);
    // start offered in the done cycle with an empty buffer
    q0.push_back(8'h5A);
    q0.push_back(8'hC6);
    xfer(0, 2, 8'h5A, 2, 34, 8'hC6, 0, 8'h00, 1, 0);
    exp_loads0 = 6;
`else
    xfer(0, 2, 8'hFF, 1, 0, 8'h00, 0, 8'h00, 0, 33);
    exp_loads0 = 2;
`endif

    // DIV=1 corner
    q1.push_back(8'h01);
`ifdef SRI_TX_DBUF_EN
    xfer(1, 1, 8'h01, 1, 0, 8'h00, 0, 8'h00, 1, 0);
`else
    xfer(1, 1, 8'h01, 1, 0, 8'h00, 0, 8'h00, 0, 16);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("dut0 load edge count", 32'(loads[0]), 32'(exp_loads0));
    chk("dut1 load edge count", 32'(loads[1]), 32'd1);
    chk("dut0 words outstanding", 32'(q0.size()), 32'd0);
    chk("dut1 words outstanding", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
